// File: rtl/mul32_shift_add.sv
// Iterative unsigned 32x32->64 shift-add multiplier built around one adder32.
// The multiplier is consumed LSB-first from acc_lo, and product bits shift in behind it.
module mul32_shift_add #(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] p
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q;
    logic [31:0] acc_hi_q;
    logic [31:0] acc_lo_q;
    logic [63:0] p_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [32:1] add_a;
    logic [32:1] add_b;
    logic [32:1] add_s;
    logic        add_c32;
    logic        sx_unused;
    logic [31:0] acc_hi_d;
    logic [31:0] acc_lo_d;
    logic        zero_hit;

    assign add_a = acc_hi_q;
    assign add_b = acc_lo_q[0] ? mcand_q : 32'd0;

    adder32 u_adder (
        .A   (add_a),
        .B   (add_b),
        .c0  (1'b0),
        .S   (add_s),
        .c32 (add_c32),
        .sx  (sx_unused)
    );

    // Carry-out becomes the new MSB; it is what makes 0xFFFFFFFF^2 come out right.
    assign acc_hi_d = {add_c32, add_s[32:2]};
    assign acc_lo_d = {add_s[1], acc_lo_q[31:1]};

    assign zero_hit = ZERO_SKIP && ((a == 32'd0) || (b == 32'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            mcand_q     <= 32'd0;
            acc_hi_q    <= 32'd0;
            acc_lo_q    <= 32'd0;
            p_q         <= 64'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q    <= a;
                        acc_hi_q   <= 32'd0;
                        acc_lo_q   <= b;
                        cnt_q      <= 5'd0;
                        in_ready_q <= 1'b0;
                        if (zero_hit) begin
                            p_q         <= 64'd0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        p_q         <= {acc_hi_d, acc_lo_d};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = p_q;
endmodule

// Ripple-carry adder whose ports are numbered [32:1]; sx flags signed overflow.
module adder32 (
    input  logic [32:1] A,
    input  logic [32:1] B,
    input  logic        c0,
    output logic [32:1] S,
    output logic        c32,
    output logic        sx
);
    logic [32:0] c;

    assign c[0] = c0;

    generate
        for (genvar gi = 1; gi <= 32; gi++) begin : g_bit
            assign S[gi] = A[gi] ^ B[gi] ^ c[gi-1];
            assign c[gi] = (A[gi] & B[gi]) | (c[gi-1] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign c32 = c[32];
    assign sx  = c[32] ^ c[31];
endmodule

// File: tb/tb_mul32_shift_add.sv
// Bench for mul32_shift_add: one instance per ZERO_SKIP setting, table of operand pairs,
// scoreboard queue of expected products, plus backpressure and async-reset sequences.
module tb_mul32_shift_add;
    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic [63:0] p_s         [2];

    int n_checks;
    int n_fail;
    logic [63:0] sb_q [$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        logic [63:0] exp_p;
        int          exp_lat;
        int          hold;
        bit          poke;
    } vec_t;

    vec_t vecs [11];

    mul32_shift_add #(.ZERO_SKIP(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_s[0]),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_s[0]),
        .out_ready (out_ready_s[0]),
        .p         (p_s[0])
    );

    mul32_shift_add #(.ZERO_SKIP(1'b1)) dut_zs (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_s[1]),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_s[1]),
        .out_ready (out_ready_s[1]),
        .p         (p_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int sel,
                         input logic [63:0] exp_p, input int exp_lat, input int hold,
                         input bit poke);
        int          k;
        bit          seen;
        logic [63:0] p_snap;
        logic [63:0] exp_pop;
        @(negedge clk);
        k = 0;
        while (!in_ready_s[sel] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_idle", 64'(in_ready_s[sel]), 64'd1);
        a = av;
        b = bv;
        in_valid_s[sel] = 1'b1;
        @(posedge clk);
        sb_q.push_back(exp_p);
        #1;
        in_valid_s[sel] = 1'b0;
        chk("in_ready_drop", 64'(in_ready_s[sel]), 64'd0);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (out_valid_s[sel]) seen = 1'b1;
        end
        chk("out_valid_seen", 64'(seen), 64'd1);
        chk("latency", 64'(k), 64'(exp_lat));
        p_snap = p_s[sel];
        for (int h = 0; h < hold; h++) begin
            if (poke && h == hold / 2) begin
                a = 32'd7;
                b = 32'd9;
                in_valid_s[sel] = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid_s[sel] = 1'b0;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid_s[sel]), 64'd1);
            chk("hold_p", p_s[sel], p_snap);
            chk("hold_in_ready", 64'(in_ready_s[sel]), 64'd0);
        end
        out_ready_s[sel] = 1'b1;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
        end else begin
            exp_pop = sb_q.pop_front();
            $display("op a=0x%08h b=0x%08h zs=%0d lat=%0d p=0x%016h exp=0x%016h",
                     av, bv, sel, k, p_s[sel], exp_pop);
            chk("product", p_s[sel], exp_pop);
        end
        @(posedge clk);
        #1;
        out_ready_s[sel] = 1'b0;
        chk("out_valid_clear", 64'(out_valid_s[sel]), 64'd0);
        chk("in_ready_back", 64'(in_ready_s[sel]), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a = 32'd0;
        b = 32'd0;
        for (int i = 0; i < 2; i++) begin
            in_valid_s[i]  = 1'b0;
            out_ready_s[i] = 1'b0;
        end

        vecs[0]  = '{32'd3,          32'd5,          0, 64'h000000000000000F, 32, 0,  1'b0};
        vecs[1]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   0, 64'hFFFFFFFE00000001, 32, 0,  1'b0};
        vecs[2]  = '{32'h80000000,   32'd2,          0, 64'h0000000100000000, 32, 0,  1'b0};
        vecs[3]  = '{32'h12345678,   32'h9ABCDEF0,   0, 64'h0B00EA4E242D2080, 32, 0,  1'b0};
        vecs[4]  = '{32'd0,          32'hDEADBEEF,   1, 64'd0,                1,  0,  1'b0};
        vecs[5]  = '{32'd0,          32'hDEADBEEF,   0, 64'd0,                32, 0,  1'b0};
        vecs[6]  = '{32'hDEADBEEF,   32'd0,          1, 64'd0,                1,  0,  1'b0};
        vecs[7]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1, 64'hFFFFFFFE00000001, 32, 0,  1'b0};
        vecs[8]  = '{32'd1,          32'hFFFFFFFF,   0, 64'h00000000FFFFFFFF, 32, 0,  1'b0};
        vecs[9]  = '{32'h0000FFFF,   32'h00010001,   0, 64'h00000000FFFFFFFF, 32, 10, 1'b1};
        vecs[10] = '{32'd7,          32'd9,          0, 64'd63,               32, 0,  1'b0};

        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", 64'(in_ready_s[i]), 64'd1);
            chk("rst_out_valid", 64'(out_valid_s[i]), 64'd0);
            chk("rst_p", p_s[i], 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp_p,
                  vecs[i].exp_lat, vecs[i].hold, vecs[i].poke);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(ra, rb, i % 2, {32'd0, ra} * {32'd0, rb}, 32, 0, 1'b0);
        end

        // Abort an operation 15 cycles into CALC with an asynchronous reset.
        @(negedge clk);
        a = 32'h0BADF00D;
        b = 32'hFFFFFFFF;
        in_valid_s[0] = 1'b1;
        @(posedge clk);
        sb_q.push_back(64'h0);
        #1;
        in_valid_s[0] = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid_s[0]), 64'd0);
        chk("async_in_ready", 64'(in_ready_s[0]), 64'd1);
        chk("async_p", p_s[0], 64'd0);
        void'(sb_q.pop_back());
        $display("op abort a=0x0BADF00D b=0xFFFFFFFF reset at CALC cycle 15");
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd6, 32'd7, 0, 64'd42, 32, 0, 1'b0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
